// File: rtl/md_ctrl.sv
// md_ctrl: issue/handshake controller between decode and the multiply/divide unit.
// Arithmetic ops start the unit and hold decode off until the unit goes idle.
// mthi/mtlo and mfhi/mflo are single-cycle transfers taken in IDLE.
// Optional feature macro: MD_DIVZERO_GUARD_EN (drop div/divu with a zero divisor).
module md_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        req_ready,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        md_start,
    output logic        md_mthi,
    output logic        md_mtlo,
    output logic [2:0]  md_op,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic        md_busy,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic [15:0] issue_cnt
);

    localparam int unsigned CW = 16;

    // Request opcodes from decode
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MFHI  = 3'd4;
    localparam logic [2:0] OP_MFLO  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    // Unit-side arithmetic encodings
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_hs;
    logic        w_div0;
    logic [CW-1:0] r_issue_cnt;

    // Zero-divisor detection, only active when the guard is built in
`ifdef MD_DIVZERO_GUARD_EN
    assign w_div0 = ((req_op == OP_DIV) || (req_op == OP_DIVU)) && (req_b == 32'd0);
`else
    assign w_div0 = 1'b0;
`endif

    assign md_a      = req_a;
    assign md_b      = req_b;
    assign issue_cnt = r_issue_cnt;

    // Accept only in IDLE with an idle unit; reset and flush both block acceptance
    assign req_ready = reset & ~flush & (r_state == S_IDLE) & ~md_busy;
    assign stall     = reset & req_valid & ~req_ready;
    assign w_hs      = req_valid & req_ready;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Issued-op counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_issue_cnt <= '0;
        end else if (md_start) begin
            r_issue_cnt <= r_issue_cnt + CW'(1);
        end
    end

    // Next state, command pulses and read-back mux
    always_comb begin
        w_next   = r_state;
        md_start = 1'b0;
        md_mthi  = 1'b0;
        md_mtlo  = 1'b0;
        rd_valid = 1'b0;
        rd_data  = 32'd0;
        md_op    = MD_MULT;

        case (req_op)
            OP_MULTU: md_op = MD_MULTU;
            OP_DIV:   md_op = MD_DIV;
            OP_DIVU:  md_op = MD_DIVU;
            default:  md_op = MD_MULT;
        endcase

        if (w_hs) begin
            case (req_op)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: md_start = ~w_div0;
                OP_MFHI: begin
                    rd_valid = 1'b1;
                    rd_data  = md_hi;
                end
                OP_MFLO: begin
                    rd_valid = 1'b1;
                    rd_data  = md_lo;
                end
                OP_MTHI: md_mthi = 1'b1;
                OP_MTLO: md_mtlo = 1'b1;
                default: ;
            endcase
        end

        // SETTLE hides the cycle before md_busy becomes visible
        case (r_state)
            S_IDLE:   if (md_start) w_next = S_SETTLE;
            S_SETTLE: w_next = S_WAIT;
            S_WAIT:   if (!md_busy) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-low; 0 clears all state immediately.
REQ-003 req_valid  in  1  a mult/div-class instruction is presented by decode.
REQ-004 req_op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mfhi, 5 mflo, 6 mthi, 7 mtlo.
REQ-005 req_a, req_b  in  32 each  rs/rt operand values.
REQ-006 flush  in  1  exception/eret cancel; a request in the same cycle is discarded.
REQ-007 req_ready  out  1  request accepted this cycle (handshake = req_valid & req_ready).
REQ-008 stall  out  1  req_valid & ~req_ready; freezes F/D.
REQ-009 rd_data  out  32  HI (mfhi) or LO (mflo) value; valid when rd_valid.
REQ-010 rd_valid  out  1  an mfhi/mflo handshake completes this cycle.
REQ-011 md_start, md_mthi, md_mtlo  out  1 each  one-cycle command pulses to the multiply/divide unit.
REQ-012 md_op  out  3  arithmetic op, using the codebase mult/multu/div/divu encodings from constants.v.
REQ-013 md_a, md_b  out  32 each  operands to the unit; equal to req_a/req_b.
REQ-014 md_busy  in  1  unit busy flag; rises the cycle after start.
REQ-015 md_hi, md_lo  in  32 each  unit architectural HI/LO.
REQ-016 issue_cnt  out  16  count of arithmetic ops issued since reset.

Function
REQ-017 FSM states SHALL be IDLE, SETTLE and WAIT, in a registered 2-bit state.
REQ-018 In IDLE with ~md_busy, req_ready SHALL be 1 and all other states SHALL drive req_ready 0.
REQ-019 An arithmetic handshake in IDLE SHALL pulse md_start with md_op = decoded req_op and SHALL move the FSM to SETTLE.
REQ-020 SETTLE SHALL last exactly one cycle and go to WAIT, covering the cycle in which md_busy is not yet visible.
REQ-021 WAIT SHALL return to IDLE on the first cycle md_busy = 0.
REQ-022 Total stall for a back-to-back dependent op SHALL be 1 + busy length cycles (mult 6, div 11).
REQ-023 An mthi/mtlo handshake SHALL pulse md_mthi or md_mtlo (never both, never with md_start); md_a = req_a; FSM stays IDLE.
REQ-024 An mfhi/mflo handshake SHALL set rd_valid = 1 and rd_data = md_hi/md_lo combinationally in the same cycle; FSM stays IDLE.
REQ-025 When flush = 1, req_ready, md_start, md_mthi, md_mtlo and rd_valid SHALL be 0 in that cycle.
REQ-026 flush SHALL NOT abort an op already in SETTLE/WAIT; the FSM SHALL complete normally.
REQ-027 issue_cnt SHALL increment by 1 per md_start pulse and SHALL wrap 0xFFFF -> 0x0000.
REQ-028 If md_busy = 1 while in IDLE (unit not started by this block), requests SHALL stall until it clears.

Reset
REQ-029 While reset = 0: state = IDLE, issue_cnt = 0, and req_ready, stall, md_start, md_mthi, md_mtlo and rd_valid SHALL be 0.
REQ-030 Reset asserted mid-op SHALL return the FSM to IDLE asynchronously; the first request after release SHALL be accepted only once md_busy = 0.

Configuration
REQ-031 The macro MD_DIVZERO_GUARD_EN SHALL control divide-by-zero handling.
REQ-032 With MD_DIVZERO_GUARD_EN defined, div/divu with req_b = 0 SHALL be accepted without md_start, FSM stays IDLE, issue_cnt is unchanged, and HI/LO keep prior values.
REQ-033 With MD_DIVZERO_GUARD_EN undefined, div/divu with req_b = 0 SHALL be issued like any other divide.

Verification
REQ-034 mult a=3 b=0xFFFFFFFE, then mflo and mfhi -> md_start 1 cycle, stall 6 cycles, rd_data 0xFFFFFFFA then 0xFFFFFFFF, issue_cnt=1.
REQ-035 divu a=7 b=2, then mfhi -> stall 11 cycles, rd_data 0x00000001; mflo -> 0x00000003.
REQ-036 mthi a=0x12345678 in IDLE, then mfhi -> md_mthi pulse only, rd_data 0x12345678 next cycle, no stall.
REQ-037 mult with flush=1 in the same cycle -> no md_start, FSM IDLE; flush in WAIT -> op completes, FSM reaches IDLE.
REQ-038 div b=0 -> guard on: no md_start, issue_cnt unchanged; guard off: md_start pulse, 11-cycle stall.
REQ-039 reset=0 during WAIT -> outputs 0 immediately, issue_cnt=0; after release with md_busy=0, mult is accepted the next cycle.
